// File: rtl/bus_pkg.sv
// Shared bus definitions: word type, widths and the select code for each bus source.
package bus_pkg;
   localparam int BUS_WIDTH = 32;
   localparam int BUS_SEL_W = 5;

   typedef logic [31:0] bus_word_t;

   // Codes 24..31 are spare inputs.
   localparam logic [4:0] SEL_R0     = 5'd0;
   localparam logic [4:0] SEL_R1     = 5'd1;
   localparam logic [4:0] SEL_R2     = 5'd2;
   localparam logic [4:0] SEL_R3     = 5'd3;
   localparam logic [4:0] SEL_R4     = 5'd4;
   localparam logic [4:0] SEL_R5     = 5'd5;
   localparam logic [4:0] SEL_R6     = 5'd6;
   localparam logic [4:0] SEL_R7     = 5'd7;
   localparam logic [4:0] SEL_R8     = 5'd8;
   localparam logic [4:0] SEL_R9     = 5'd9;
   localparam logic [4:0] SEL_R10    = 5'd10;
   localparam logic [4:0] SEL_R11    = 5'd11;
   localparam logic [4:0] SEL_R12    = 5'd12;
   localparam logic [4:0] SEL_R13    = 5'd13;
   localparam logic [4:0] SEL_R14    = 5'd14;
   localparam logic [4:0] SEL_R15    = 5'd15;
   localparam logic [4:0] SEL_HI     = 5'd16;
   localparam logic [4:0] SEL_LO     = 5'd17;
   localparam logic [4:0] SEL_ZHI    = 5'd18;
   localparam logic [4:0] SEL_ZLO    = 5'd19;
   localparam logic [4:0] SEL_PC     = 5'd20;
   localparam logic [4:0] SEL_MDR    = 5'd21;
   localparam logic [4:0] SEL_INPORT = 5'd22;
   localparam logic [4:0] SEL_C      = 5'd23;
endpackage

// File: rtl/mux32_comb.sv
// Combinational NUM_IN:1 word mux; every select code maps directly to the same-numbered input.
module mux32_comb #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 32
) (
   input  logic [WIDTH-1:0]          words [NUM_IN],
   input  logic [$clog2(NUM_IN)-1:0] select,
   output logic [WIDTH-1:0]          sel_word
);
   always_comb begin
      sel_word = words[select];
   end
endmodule

// File: rtl/bus_mux32_reg.sv
// Registered 32:1 bus mux: selected input is captured on the clock edge when en is high.
module bus_mux32_reg
   import bus_pkg::*;
#(
   parameter int WIDTH  = BUS_WIDTH,
   parameter int NUM_IN = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [BUS_SEL_W-1:0] select,
   input  logic [WIDTH-1:0]     in0,
   input  logic [WIDTH-1:0]     in1,
   input  logic [WIDTH-1:0]     in2,
   input  logic [WIDTH-1:0]     in3,
   input  logic [WIDTH-1:0]     in4,
   input  logic [WIDTH-1:0]     in5,
   input  logic [WIDTH-1:0]     in6,
   input  logic [WIDTH-1:0]     in7,
   input  logic [WIDTH-1:0]     in8,
   input  logic [WIDTH-1:0]     in9,
   input  logic [WIDTH-1:0]     in10,
   input  logic [WIDTH-1:0]     in11,
   input  logic [WIDTH-1:0]     in12,
   input  logic [WIDTH-1:0]     in13,
   input  logic [WIDTH-1:0]     in14,
   input  logic [WIDTH-1:0]     in15,
   input  logic [WIDTH-1:0]     in16,
   input  logic [WIDTH-1:0]     in17,
   input  logic [WIDTH-1:0]     in18,
   input  logic [WIDTH-1:0]     in19,
   input  logic [WIDTH-1:0]     in20,
   input  logic [WIDTH-1:0]     in21,
   input  logic [WIDTH-1:0]     in22,
   input  logic [WIDTH-1:0]     in23,
   input  logic [WIDTH-1:0]     in24,
   input  logic [WIDTH-1:0]     in25,
   input  logic [WIDTH-1:0]     in26,
   input  logic [WIDTH-1:0]     in27,
   input  logic [WIDTH-1:0]     in28,
   input  logic [WIDTH-1:0]     in29,
   input  logic [WIDTH-1:0]     in30,
   input  logic [WIDTH-1:0]     in31,
   output logic [WIDTH-1:0]     out_signal
);
   logic [WIDTH-1:0] words [NUM_IN];
   logic [WIDTH-1:0] sel_word;

   // Gather the named inputs into an array so the mux index equals the input number.
   assign words[0]  = in0;
   assign words[1]  = in1;
   assign words[2]  = in2;
   assign words[3]  = in3;
   assign words[4]  = in4;
   assign words[5]  = in5;
   assign words[6]  = in6;
   assign words[7]  = in7;
   assign words[8]  = in8;
   assign words[9]  = in9;
   assign words[10] = in10;
   assign words[11] = in11;
   assign words[12] = in12;
   assign words[13] = in13;
   assign words[14] = in14;
   assign words[15] = in15;
   assign words[16] = in16;
   assign words[17] = in17;
   assign words[18] = in18;
   assign words[19] = in19;
   assign words[20] = in20;
   assign words[21] = in21;
   assign words[22] = in22;
   assign words[23] = in23;
   assign words[24] = in24;
   assign words[25] = in25;
   assign words[26] = in26;
   assign words[27] = in27;
   assign words[28] = in28;
   assign words[29] = in29;
   assign words[30] = in30;
   assign words[31] = in31;

   mux32_comb #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) u_mux (
      .words    (words),
      .select   (select),
      .sel_word (sel_word)
   );

   // Reset clears the bus at once; release takes effect on the next rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_signal <= '0;
      end else if (en) begin
         out_signal <= sel_word;
      end
   end
endmodule

// File: tb/tb_bus_mux32_reg.sv
// Self-checking bench for bus_mux32_reg: vector table plus hand-written multi-cycle sequences.
module tb_bus_mux32_reg;
   import bus_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [4:0]  select;
   logic [31:0] in_v [32];
   logic [31:0] out_signal;

   logic [31:0] exp_q [$];
   logic [31:0] model;
   int          n_checks;
   int          n_pass;

   typedef struct {
      logic [4:0]  sel;
      logic        en;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [36];

   bus_mux32_reg dut (
      .clk (clk), .rst_n (rst_n), .en (en), .select (select),
      .in0 (in_v[0]),   .in1 (in_v[1]),   .in2 (in_v[2]),   .in3 (in_v[3]),
      .in4 (in_v[4]),   .in5 (in_v[5]),   .in6 (in_v[6]),   .in7 (in_v[7]),
      .in8 (in_v[8]),   .in9 (in_v[9]),   .in10 (in_v[10]), .in11 (in_v[11]),
      .in12 (in_v[12]), .in13 (in_v[13]), .in14 (in_v[14]), .in15 (in_v[15]),
      .in16 (in_v[16]), .in17 (in_v[17]), .in18 (in_v[18]), .in19 (in_v[19]),
      .in20 (in_v[20]), .in21 (in_v[21]), .in22 (in_v[22]), .in23 (in_v[23]),
      .in24 (in_v[24]), .in25 (in_v[25]), .in26 (in_v[26]), .in27 (in_v[27]),
      .in28 (in_v[28]), .in29 (in_v[29]), .in30 (in_v[30]), .in31 (in_v[31]),
      .out_signal (out_signal)
   );

   // Clock: period 10, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle, push its expected output, then compare just after the capturing edge.
   task automatic drive(input logic [4:0] s, input logic e, input logic [31:0] x, input string name);
      @(negedge clk);
      select = s;
      en     = e;
      exp_q.push_back(x);
      model  = x;
      @(posedge clk);
      #1;
      check(name, out_signal, exp_q.pop_front());
   endtask

   task automatic step(input logic [4:0] s, input logic e, input string name);
      drive(s, e, e ? in_v[s] : model, name);
   endtask

   task automatic load_onehot();
      for (int k = 0; k < 32; k++) in_v[k] = 32'h1 << k;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      model    = '0;
      rst_n    = 1'b1;
      en       = 1'b1;
      select   = 5'd0;
      load_onehot();

      // Reset asserted mid-cycle clears the output with no clock edge.
      #2 rst_n = 1'b0;
      #1 check("reset_async", out_signal, 32'h0);
      repeat (2) begin
         @(posedge clk);
         #1 check("reset_hold", out_signal, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Vector table: walk every select code, then a few hold/capture vectors.
      for (int k = 0; k < 32; k++) vecs[k] = '{k[4:0], 1'b1, 32'h1 << k};
      vecs[32] = '{5'd3,  1'b0, 32'h8000_0000};
      vecs[33] = '{5'd10, 1'b0, 32'h8000_0000};
      vecs[34] = '{5'd0,  1'b1, 32'h0000_0001};
      vecs[35] = '{5'd31, 1'b1, 32'h8000_0000};
      for (int i = 0; i < 36; i++) begin
         drive(vecs[i].sel, vecs[i].en, vecs[i].exp, $sformatf("table[%0d]", i));
      end

      // Select change between edges must not reach the output until the next edge.
      drive(5'd3, 1'b1, 32'h0000_0008, "latency_pre");
      @(negedge clk);
      select = 5'd9;
      #2 check("no_comb_path", out_signal, 32'h0000_0008);
      @(posedge clk);
      #1 check("latency_post", out_signal, 32'h0000_0200);
      model = 32'h0000_0200;

      // Hold with en low while select and the old source both change.
      drive(SEL_R5, 1'b1, 32'h0000_0020, "hold_capture");
      @(negedge clk);
      en      = 1'b0;
      select  = SEL_PC;
      in_v[5] = 32'hDEAD_BEEF;
      #1 check("hold_now", out_signal, 32'h0000_0020);
      repeat (2) begin
         @(posedge clk);
         #1 check("hold_edge", out_signal, 32'h0000_0020);
      end
      drive(SEL_PC, 1'b1, 32'h0010_0000, "hold_release");
      load_onehot();

      // Data tracking on a fixed select while the other inputs toggle randomly.
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 32; k++) if (k != 17) in_v[k] = $urandom;
         in_v[17] = (r % 2 == 0) ? 32'hFFFF_FFFF : 32'h1234_5678;
         drive(SEL_LO, 1'b1, (r % 2 == 0) ? 32'hFFFF_FFFF : 32'h1234_5678, "data_track");
      end
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 32; k++) in_v[k] = $urandom;
         step(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), "random");
      end

      // Reset mid-operation, then release between edges.
      @(posedge clk);
      #3 rst_n = 1'b0;
      model = '0;
      #1 check("reset_mid", out_signal, 32'h0);
      repeat (2) begin
         @(posedge clk);
         #1 check("reset_mid_hold", out_signal, 32'h0);
      end
      @(negedge clk);
      select  = 5'd0;
      in_v[0] = 32'hA5A5_A5A5;
      en      = 1'b1;
      #2 rst_n = 1'b1;
      #1 check("release_pre", out_signal, 32'h0);
      @(posedge clk);
      #1 check("release_post", out_signal, 32'hA5A5_A5A5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/bus_mux32_reg.md
Name:
bus_mux32_reg

Overview:
- Registered 32-input, 32-bit-wide multiplexer for the datapath's shared bus.
- A 5-bit select picks one of 32 word inputs, in0..in31, and drives it onto the bus output.
- The output is registered: it updates on the clock edge after select/data settle, giving the bus a clean, glitch-free source.
- Sits between register-file/special-register outputs (R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C, spares) and the bus consumers.

Parameters:
- WIDTH, 32, data width of every input and of the output.
- NUM_IN, 32, number of inputs; fixed at 32 (select width is log2(NUM_IN) = 5); other values are not supported.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  load enable for the output register; 1 = capture the selected input.
- select  input  5  index of the input to route; 0 selects in0 … 31 selects in31.
- in0..in31  input  WIDTH each  data inputs; inK is routed when select == K.
- out_signal  output  WIDTH  registered bus output.

Behaviour:
- Reset:
  - rst_n low clears out_signal to 32'h0000_0000 immediately, with no clock edge needed.
  - Reset dominates en and select.
  - Release is sampled synchronously: the first capture happens on the first rising edge with rst_n high.
- Selection is purely combinational inside: sel_word = in[select]. Mapping is exact index, no offset or inversion. All 32 codes are valid; there is no default/out-of-range case.
- Capture: on a rising clk edge with rst_n high and en high, out_signal <= sel_word.
- Hold: en low keeps the previous out_signal value.
- Latency: one clock from a select or data change to out_signal.
- Data inputs are sampled only at the edge. Changes between edges have no effect; there is no combinational path from any input to out_signal.
- Simultaneous select and data change before an edge: the value captured is whatever in[select] equals at setup time.
- Reset asserted mid-operation: out_signal goes to 0 at once and stays 0 while rst_n is low, regardless of clk.
- Width rule: bit-for-bit pass-through. No sign extension, no arithmetic, no partial-width lanes.
- out_signal never shows X after reset, provided the inputs are known.

Decomposition:
- Shared package bus_pkg holds:
  - constants BUS_WIDTH = 32, BUS_SEL_W = 5;
  - a typedef bus_word_t (logic [31:0]);
  - localparams naming the select codes in order (SEL_R0 = 0 … SEL_R15 = 15, SEL_HI = 16, SEL_LO = 17, SEL_ZHI = 18, SEL_ZLO = 19, SEL_PC = 20, SEL_MDR = 21, SEL_INPORT = 22, SEL_C = 23, 24–31 spare).
- One natural sub-module: mux32_comb, the combinational 32:1 WIDTH-bit case mux. The top instantiates it and adds the enable/reset output register.

Test Plan:
- Reset: set inK = 2**K for all K and en = 1, then assert rst_n = 0 mid-cycle -> out_signal = 0 immediately and stays 0 across clock edges until release.
- Walk select 0..31, one code per clock, with inK = 2**K and en = 1 -> the edge after select = K gives out_signal = 32'h1 << K. Checks all 32 codes, including select = 31 -> 32'h8000_0000.
- Latency/no combinational path: change select from 3 to 9 between edges -> out_signal stays 32'h0000_0008 until the next rising edge, then becomes 32'h0000_0200.
- Hold: capture select = 5 (out_signal = 32'h20), then drive en = 0, change select to 20 and in5 to 32'hDEAD_BEEF -> out_signal stays 32'h20 until en returns to 1.
- Data tracking: fix select = 17, en = 1, drive in17 = 32'hFFFF_FFFF then 32'h1234_5678 on consecutive cycles -> out_signal follows each value one edge later; the other 31 inputs toggling randomly have no effect.
- Reset release: deassert rst_n between edges with select = 0 and in0 = 32'hA5A5_A5A5 -> out_signal stays 0 until the first rising edge, then becomes 32'hA5A5_A5A5.
